uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types: receiver FSM states, baud divisor table, majority helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // clk cycles per 16x oversample tick at 50 MHz
  function automatic logic [13:0] div_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    return 14'd10417;
      4'd1:    return 14'd5208;
      4'd2:    return 14'd2604;
      4'd3:    return 14'd1302;
      4'd4:    return 14'd651;
      4'd5:    return 14'd326;
      4'd6:    return 14'd163;
      4'd7:    return 14'd81;
      4'd8:    return 14'd54;
      4'd9:    return 14'd27;
      4'd10:   return 14'd14;
      4'd11:   return 14'd7;
      default: return 14'd3;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversample tick generator, one tick every i_div clk cycles
module uart_baud_tick (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_restart,
  input  logic [13:0] i_div,
  output logic        o_tick
);

  logic [13:0] r_cnt;
  logic        w_last;

  assign w_last = (r_cnt == i_div - 14'd1);
  assign o_tick = w_last && !i_restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 14'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 16x oversampled, 7/8 data bits, optional parity, overrun flag
// Define UART_RX_FILTER_EN for 2-of-3 majority sampling at ticks 7, 8 and 9 of each bit.
module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  input  logic [3:0] Baud_Val,
  input  logic       ParityEn,
  input  logic       ParityOE,
  input  logic       Bit78,
  input  logic       RxRead,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overrun
);
  import uart_pkg::*;

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  uart_state_t r_state;
  logic [3:0]  r_tcnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [13:0] r_div;
  logic        r_par_en, r_par_odd, r_bit8, r_perr;
  logic        w_tick, w_fall, w_decide, w_bit, w_bit_end;
  logic [7:0]  w_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall    = (r_state == ST_IDLE) && r_rx_prev && !r_rx_sync;
  assign w_bit_end = w_tick && (r_tcnt == 4'd15);
  assign w_data    = r_bit8 ? r_shift : {1'b0, r_shift[7:1]};

  uart_baud_tick u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_fall),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

`ifdef UART_RX_FILTER_EN
  logic r_s7, r_s8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else if (w_tick) begin
      if (r_tcnt == 4'd6) r_s7 <= r_rx_sync;
      if (r_tcnt == 4'd7) r_s8 <= r_rx_sync;
    end
  end

  assign w_decide = w_tick && (r_tcnt == 4'd8);
  assign w_bit    = maj3(r_s7, r_s8, r_rx_sync);
`else
  assign w_decide = w_tick && (r_tcnt == 4'd7);
  assign w_bit    = r_rx_sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tcnt    <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_div     <= 14'd3;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_bit8    <= 1'b0;
      r_perr    <= 1'b0;
      RxData    <= '0;
      RxValid   <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (RxRead && RxValid) begin
        RxValid   <= 1'b0;
        ParityErr <= 1'b0;
        FrameErr  <= 1'b0;
        Overrun   <= 1'b0;
      end
      if (w_tick && r_state != ST_IDLE) r_tcnt <= r_tcnt + 4'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state   <= ST_START;
            r_tcnt    <= '0;
            r_div     <= div_lookup(Baud_Val);
            r_par_en  <= ParityEn;
            r_par_odd <= ParityOE;
            r_bit8    <= Bit78;
            r_perr    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_decide && w_bit) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_bit, r_shift[7:1]};
          if (w_bit_end) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == (r_bit8 ? 3'd7 : 3'd6)) r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_decide) r_perr <= (^w_data) ^ w_bit ^ r_par_odd;
          if (w_bit_end) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_decide) begin
            r_state <= ST_IDLE;
            // an unread character wins over the new one; a same-cycle read frees the slot
            if (RxValid && !RxRead) begin
              Overrun <= 1'b1;
            end else begin
              RxData    <= w_data;
              RxValid   <= 1'b1;
              ParityErr <= r_perr;
              FrameErr  <= !w_bit;
              Overrun   <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized frames and a reference model
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic [3:0] Baud_Val = 4'd12;
  logic       ParityEn = 1'b0;
  logic       ParityOE = 1'b0;
  logic       Bit78 = 1'b1;
  logic       RxRead = 1'b0;
  logic [7:0] RxData;
  logic       RxValid, ParityErr, FrameErr, Overrun;

  int n_vec = 0;
  int n_err = 0;
  int lat_cycles;

  always #10 clk = ~clk;

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .RX        (RX),
    .Baud_Val  (Baud_Val),
    .ParityEn  (ParityEn),
    .ParityOE  (ParityOE),
    .Bit78     (Bit78),
    .RxRead    (RxRead),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .ParityErr (ParityErr),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun)
  );

  function automatic int div_of(input int idx);
    case (idx)
      0: return 10417;  1: return 5208;  2: return 2604;  3: return 1302;
      4: return 651;    5: return 326;   6: return 163;   7: return 81;
      8: return 54;     9: return 27;    10: return 14;   11: return 7;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] b, input logic bit8);
    int v;
    v = b;
    return bit8 ? b : 8'(v % 128);
  endfunction

  function automatic logic model_perr(input logic [7:0] b, input logic bit8, input logic pen,
                                      input logic podd, input logic pbit);
    int ones, v, nb;
    v = b;
    ones = pbit ? 1 : 0;
    nb = bit8 ? 8 : 7;
    for (int i = 0; i < nb; i++) ones += (v >> i) & 1;
    if (!pen) return 1'b0;
    return podd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Drives a full frame cycle by cycle; read_at > 0 pulses RxRead for the cycle before posedge read_at
  task automatic send_frame(input logic [7:0] b, input int baud, input logic bit8, input logic pen,
                            input logic podd, input logic pbit, input logic stopv, input int read_at);
    logic bits[$];
    int bitlen, total, nd;
    @(negedge clk);
    Baud_Val = 4'(baud);
    Bit78 = bit8;
    ParityEn = pen;
    ParityOE = podd;
    nd = bit8 ? 8 : 7;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(b[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stopv);
    bitlen = 16 * div_of(baud);
    total = bitlen * bits.size();
    lat_cycles = -1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (RxValid && lat_cycles < 0) lat_cycles = c;
      RX = bits[c / bitlen];
      RxRead = (read_at > 0 && c == read_at - 1);
    end
    @(negedge clk);
    RX = 1'b1;
    RxRead = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    RxRead = 1'b1;
    @(negedge clk);
    RxRead = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (RxData !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", RxData); end
    n_vec++; if (RxValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", RxValid); end
    n_vec++; if ({ParityErr, FrameErr, Overrun} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {ParityErr, FrameErr, Overrun});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (RxData !== 8'hA5) begin n_err++; $display("FAIL 8n1_data: got %h expected a5", RxData); end
    n_vec++; if (RxValid !== 1'b1) begin n_err++; $display("FAIL 8n1_valid: got %b expected 1", RxValid); end
    n_vec++; if ({ParityErr, FrameErr, Overrun} !== 3'b000) begin
      n_err++; $display("FAIL 8n1_flags: got %b expected 000", {ParityErr, FrameErr, Overrun});
    end
    n_vec++; if (lat_cycles < 4104 || lat_cycles > 4110) begin
      n_err++; $display("FAIL 8n1_latency: got %0d expected 4104..4110", lat_cycles);
    end
    read_pulse();
    n_vec++; if (RxValid !== 1'b0) begin n_err++; $display("FAIL 8n1_read: got %b expected 0", RxValid); end
  endtask

  task automatic test_parity_err();
    send_frame(8'h37, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (RxData !== 8'h37) begin n_err++; $display("FAIL par_data: got %h expected 37", RxData); end
    n_vec++; if (ParityErr !== 1'b1) begin n_err++; $display("FAIL par_err: got %b expected 1", ParityErr); end
    n_vec++; if (FrameErr !== 1'b0) begin n_err++; $display("FAIL par_ferr: got %b expected 0", FrameErr); end
    read_pulse();
  endtask

  task automatic test_7bit_frame_err();
    send_frame(8'h7F, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (RxData !== 8'h7F) begin n_err++; $display("FAIL b7_data: got %h expected 7f", RxData); end
    n_vec++; if (FrameErr !== 1'b1) begin n_err++; $display("FAIL b7_ferr: got %b expected 1", FrameErr); end
    n_vec++; if (ParityErr !== 1'b0) begin n_err++; $display("FAIL b7_perr: got %b expected 0", ParityErr); end
    read_pulse();
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'hC3, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (RxData !== 8'h3C) begin n_err++; $display("FAIL ovr_data: got %h expected 3c", RxData); end
    n_vec++; if (Overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b expected 1", Overrun); end
    n_vec++; if (RxValid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", RxValid); end
    read_pulse();
    n_vec++; if (RxValid !== 1'b0) begin n_err++; $display("FAIL ovr_read_valid: got %b expected 0", RxValid); end
    n_vec++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL ovr_read_flag: got %b expected 0", Overrun); end
  endtask

  task automatic test_back_to_back();
    int n_at;
    send_frame(8'h11, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n_at = 3 + div_of(12) * (8 + 16 * 9);
    send_frame(8'h22, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, n_at);
    n_vec++; if (RxData !== 8'h22) begin n_err++; $display("FAIL b2b_data: got %h expected 22", RxData); end
    n_vec++; if (RxValid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b expected 1", RxValid); end
    n_vec++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr: got %b expected 0", Overrun); end
    read_pulse();
  endtask

  task automatic test_glitch();
    @(negedge clk);
    Baud_Val = 4'd12;
    RX = 1'b0;
    repeat (3 * div_of(12)) @(negedge clk);
    RX = 1'b1;
    repeat (16 * 12 * div_of(12)) @(negedge clk);
    n_vec++; if (RxValid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b expected 0", RxValid); end
    n_vec++; if ({ParityErr, FrameErr, Overrun} !== 3'b000) begin
      n_err++; $display("FAIL glitch_flags: got %b expected 000", {ParityErr, FrameErr, Overrun});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int bitlen;
    send_frame(8'h5A, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    b = 8'h96;
    bitlen = 16 * div_of(12);
    @(negedge clk);
    RX = 1'b0;
    repeat (bitlen) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RX = b[i];
      repeat (bitlen) @(negedge clk);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (RxData !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h expected 00", RxData); end
    n_vec++; if ({RxValid, ParityErr, FrameErr, Overrun} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_status: got %b expected 0000", {RxValid, ParityErr, FrameErr, Overrun});
    end
    RX = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(b, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (RxData !== 8'h96) begin n_err++; $display("FAIL rst_next_data: got %h expected 96", RxData); end
    n_vec++; if (RxValid !== 1'b1) begin n_err++; $display("FAIL rst_next_valid: got %b expected 1", RxValid); end
    read_pulse();
  endtask

  task automatic test_random();
    logic [7:0] b, exp_d;
    logic bit8, pen, podd, pbit, stopv, exp_pe;
    int baud;
    for (int k = 0; k < 10; k++) begin
      b     = 8'($urandom_range(0, 255));
      baud  = $urandom_range(10, 15);
      bit8  = 1'($urandom_range(0, 1));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      stopv = ($urandom_range(0, 3) != 0);
      exp_d  = model_data(b, bit8);
      exp_pe = model_perr(b, bit8, pen, podd, pbit);
      send_frame(b, baud, bit8, pen, podd, pbit, stopv, 0);
      n_vec++; if (RxData !== exp_d) begin
        n_err++; $display("FAIL rnd%0d_data: got %h expected %h", k, RxData, exp_d);
      end
      n_vec++; if ({RxValid, ParityErr, FrameErr, Overrun} !== {1'b1, exp_pe, !stopv, 1'b0}) begin
        n_err++; $display("FAIL rnd%0d_status: got %b expected %b", k,
                          {RxValid, ParityErr, FrameErr, Overrun}, {1'b1, exp_pe, !stopv, 1'b0});
      end
      read_pulse();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_err();
    test_7bit_frame_err();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
